// File: rtl/if_bus_master_pkg.sv
// rtl/if_bus_master_pkg.sv - shared stall encodings, NOP word and fetch FSM states
package if_bus_master_pkg;

    localparam logic STOP = 1'b1;
    localparam logic NOSTOP = 1'b0;
    localparam int STALL_IF_ID = 1;
    localparam logic [31:0] NOP_INST_WORD = 32'h00000013;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_REQ     = 2'd1,
        IF_DISCARD = 2'd2,
        IF_HOLD    = 2'd3
    } if_state_e;

    function automatic logic if_stopped(input logic [5:0] stall);
        return stall[STALL_IF_ID] != NOSTOP;
    endfunction

endpackage

// File: rtl/if_timeout_ctr.sv
// rtl/if_timeout_ctr.sv - saturating 8-bit wait counter for an outstanding fetch
module if_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk_in) begin
        if (reset_in || clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // Count starts at 0 on the first waiting cycle, so this fires on the TIMEOUT_CYCLES-th one.
    assign expired = (count >= 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/if_bus_master.sv
// rtl/if_bus_master.sv - turns PC fetches into req/ack instruction bus reads for IF/ID
module if_bus_master
    import if_bus_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] NOP_INST = DATA_WIDTH'(NOP_INST_WORD)
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic                  chip_enable_in,
    input  logic [5:0]            stall_in,
    input  logic                  flush_in,
    output logic                  bus_req_out,
    output logic [ADDR_WIDTH-1:0] bus_addr_out,
    input  logic                  bus_ack_in,
    input  logic                  bus_err_in,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  stall_req_out,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc_out,
    output logic                  inst_valid_out,
    output logic                  fetch_err_out
);

    if_state_e             state;
    logic [DATA_WIDTH-1:0] hold_data;
    logic [ADDR_WIDTH-1:0] hold_pc;
    logic                  valid_q;
    logic                  stopped;
    logic                  done;
    logic                  tmr_clear;
    logic                  tmr_en;
    logic                  expired;

    assign stopped = if_stopped(stall_in);
    assign done    = bus_ack_in | bus_err_in;

    // Counter idles at zero outside the wait states and restarts when a flush turns REQ into DISCARD.
    assign tmr_en    = (state == IF_REQ) || (state == IF_DISCARD);
    assign tmr_clear = (state == IF_IDLE) || (state == IF_HOLD) ||
                       ((state == IF_REQ) && flush_in && !done);

    if_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in  (clk_in),
        .reset_in(reset_in),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (expired)
    );

    // PC holds unless the word for the current fetch is landing this cycle.
    assign stall_req_out  = chip_enable_in & ~((state == IF_REQ) & done & ~flush_in);
    assign inst_valid_out = valid_q & ~flush_in;

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state         <= IF_IDLE;
            bus_req_out   <= 1'b0;
            bus_addr_out  <= '0;
            inst_out      <= NOP_INST;
            inst_pc_out   <= '0;
            valid_q       <= 1'b0;
            fetch_err_out <= 1'b0;
            hold_data     <= NOP_INST;
            hold_pc       <= '0;
        end else begin
            valid_q       <= 1'b0;
            fetch_err_out <= 1'b0;
            inst_out      <= NOP_INST;
            case (state)
                IF_IDLE: begin
                    if (chip_enable_in && !flush_in && !stopped) begin
                        bus_req_out  <= 1'b1;
                        bus_addr_out <= pc_in;
                        state        <= IF_REQ;
                    end
                end
                IF_REQ: begin
                    if (done && flush_in) begin
                        bus_req_out <= 1'b0;
                        state       <= IF_IDLE;
                    end else if (bus_ack_in) begin
                        bus_req_out <= 1'b0;
                        if (stopped) begin
                            hold_data <= bus_data_in;
                            hold_pc   <= bus_addr_out;
                            state     <= IF_HOLD;
                        end else begin
                            inst_out    <= bus_data_in;
                            inst_pc_out <= bus_addr_out;
                            valid_q     <= 1'b1;
                            state       <= IF_IDLE;
                        end
                    end else if (bus_err_in || (expired && !flush_in)) begin
                        bus_req_out   <= 1'b0;
                        inst_pc_out   <= bus_addr_out;
                        valid_q       <= 1'b1;
                        fetch_err_out <= 1'b1;
                        state         <= IF_IDLE;
                    end else if (flush_in) begin
                        // The bus cannot cancel, so keep req up and swallow the reply.
                        state <= IF_DISCARD;
                    end
                end
                IF_DISCARD: begin
                    if (done || expired) begin
                        bus_req_out <= 1'b0;
                        state       <= IF_IDLE;
                    end
                end
                IF_HOLD: begin
                    if (flush_in) begin
                        hold_data <= NOP_INST;
                        state     <= IF_IDLE;
                    end else if (!stopped) begin
                        inst_out    <= hold_data;
                        inst_pc_out <= hold_pc;
                        valid_q     <= 1'b1;
                        state       <= IF_IDLE;
                    end
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_bus_master.sv
// tb/tb_if_bus_master.sv - directed vector bench for if_bus_master
module tb_if_bus_master;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk_in;
    logic        reset_in;
    logic [31:0] pc_in;
    logic        chip_enable_in;
    logic [5:0]  stall_in;
    logic        flush_in;
    logic        bus_req_out;
    logic [31:0] bus_addr_out;
    logic        bus_ack_in;
    logic        bus_err_in;
    logic [31:0] bus_data_in;
    logic        stall_req_out;
    logic [31:0] inst_out;
    logic [31:0] inst_pc_out;
    logic        inst_valid_out;
    logic        fetch_err_out;

    int n_cmp = 0;
    int n_bad = 0;

    if_bus_master dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .pc_in         (pc_in),
        .chip_enable_in(chip_enable_in),
        .stall_in      (stall_in),
        .flush_in      (flush_in),
        .bus_req_out   (bus_req_out),
        .bus_addr_out  (bus_addr_out),
        .bus_ack_in    (bus_ack_in),
        .bus_err_in    (bus_err_in),
        .bus_data_in   (bus_data_in),
        .stall_req_out (stall_req_out),
        .inst_out      (inst_out),
        .inst_pc_out   (inst_pc_out),
        .inst_valid_out(inst_valid_out),
        .fetch_err_out (fetch_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        ce;
        logic [31:0] pc;
        logic        stop;
        logic        flush;
        logic        ack;
        logic        err;
        logic [31:0] data;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_stall;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        e_err;
    } vec_t;

    vec_t vt[26];

    function automatic vec_t mk(input logic ce, input logic [31:0] pc, input logic stop,
                                input logic flush, input logic ack, input logic err,
                                input logic [31:0] data, input logic e_req,
                                input logic [31:0] e_addr, input logic e_stall,
                                input logic e_valid, input logic [31:0] e_inst,
                                input logic [31:0] e_ipc, input logic e_err);
        vec_t v;
        v.ce = ce; v.pc = pc; v.stop = stop; v.flush = flush; v.ack = ack; v.err = err;
        v.data = data; v.e_req = e_req; v.e_addr = e_addr; v.e_stall = e_stall;
        v.e_valid = e_valid; v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change #1 after the rising edge; checks happen at the following falling edge.
    task automatic drive(input logic ce, input logic [31:0] pc, input logic stop,
                         input logic flush, input logic ack, input logic err,
                         input logic [31:0] data);
        chip_enable_in = ce;
        pc_in          = pc;
        stall_in       = {4'b0000, stop, 1'b0};
        flush_in       = flush;
        bus_ack_in     = ack;
        bus_err_in     = err;
        bus_data_in    = data;
        @(negedge clk_in);
    endtask

    task automatic adv();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic gone;

        vt[0]  = mk(1, 32'h00, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[1]  = mk(1, 32'h00, 0, 0, 1, 0, 32'h00500093, 1, 32'h00, 0, 0, NOP,          32'h00, 0);
        vt[2]  = mk(1, 32'h04, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 1, 32'h00500093, 32'h00, 0);
        vt[3]  = mk(1, 32'h04, 0, 0, 0, 0, 32'h0,        1, 32'h04, 1, 0, NOP,          32'h00, 0);
        vt[4]  = mk(1, 32'h04, 0, 0, 0, 0, 32'h0,        1, 32'h04, 1, 0, NOP,          32'h00, 0);
        vt[5]  = mk(1, 32'h04, 0, 0, 1, 0, 32'hDEADBEEF, 1, 32'h04, 0, 0, NOP,          32'h00, 0);
        vt[6]  = mk(0, 32'h08, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 1, 32'hDEADBEEF, 32'h04, 0);
        vt[7]  = mk(1, 32'h08, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[8]  = mk(1, 32'h08, 1, 0, 1, 0, 32'h12345678, 1, 32'h08, 0, 0, NOP,          32'h00, 0);
        vt[9]  = mk(1, 32'h08, 1, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[10] = mk(1, 32'h08, 1, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[11] = mk(1, 32'h08, 1, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[12] = mk(1, 32'h08, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[13] = mk(0, 32'h08, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 1, 32'h12345678, 32'h08, 0);
        vt[14] = mk(0, 32'h08, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 0, NOP,          32'h00, 0);
        vt[15] = mk(1, 32'h10, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[16] = mk(1, 32'h10, 0, 0, 0, 1, 32'h0,        1, 32'h10, 0, 0, NOP,          32'h00, 0);
        vt[17] = mk(0, 32'h14, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 1, NOP,          32'h10, 1);
        vt[18] = mk(0, 32'h14, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 0, NOP,          32'h00, 0);
        vt[19] = mk(1, 32'h14, 0, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[20] = mk(1, 32'h14, 0, 1, 1, 0, 32'hAAAA5555, 1, 32'h14, 1, 0, NOP,          32'h00, 0);
        vt[21] = mk(0, 32'h18, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 0, NOP,          32'h00, 0);
        vt[22] = mk(1, 32'h18, 0, 1, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[23] = mk(0, 32'h18, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 0, NOP,          32'h00, 0);
        vt[24] = mk(1, 32'h18, 1, 0, 0, 0, 32'h0,        0, 32'h00, 1, 0, NOP,          32'h00, 0);
        vt[25] = mk(0, 32'h18, 0, 0, 0, 0, 32'h0,        0, 32'h00, 0, 0, NOP,          32'h00, 0);

        reset_in = 1'b1;
        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        adv();
        adv();
        reset_in = 1'b0;

        drive(0, 32'h0, 0, 0, 0, 0, 32'h0);
        chk("rst_req",   32'(bus_req_out), 0);
        chk("rst_addr",  bus_addr_out, 0);
        chk("rst_inst",  inst_out, NOP);
        chk("rst_ipc",   inst_pc_out, 0);
        chk("rst_valid", 32'(inst_valid_out), 0);
        chk("rst_err",   32'(fetch_err_out), 0);
        adv();

        for (int i = 0; i < 26; i++) begin
            drive(vt[i].ce, vt[i].pc, vt[i].stop, vt[i].flush, vt[i].ack, vt[i].err, vt[i].data);
            chk($sformatf("v%0d_req", i),   32'(bus_req_out),    32'(vt[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(stall_req_out),  32'(vt[i].e_stall));
            chk($sformatf("v%0d_valid", i), 32'(inst_valid_out), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_inst", i),  inst_out,            vt[i].e_inst);
            chk($sformatf("v%0d_ferr", i),  32'(fetch_err_out),  32'(vt[i].e_err));
            if (vt[i].e_req)   chk($sformatf("v%0d_addr", i), bus_addr_out, vt[i].e_addr);
            if (vt[i].e_valid) chk($sformatf("v%0d_ipc", i),  inst_pc_out,  vt[i].e_ipc);
            adv();
        end

        // Flush while waiting, reply two cycles later, redirect to 0x100.
        drive(1, 32'h20, 0, 0, 0, 0, 32'h0);
        chk("fl_a_stall", 32'(stall_req_out), 1);
        adv();
        drive(1, 32'h100, 0, 1, 0, 0, 32'h0);
        chk("fl_b_req",   32'(bus_req_out), 1);
        chk("fl_b_addr",  bus_addr_out, 32'h20);
        chk("fl_b_valid", 32'(inst_valid_out), 0);
        adv();
        drive(1, 32'h100, 0, 1, 0, 0, 32'h0);
        chk("fl_c_req",   32'(bus_req_out), 1);
        chk("fl_c_addr",  bus_addr_out, 32'h20);
        chk("fl_c_stall", 32'(stall_req_out), 1);
        adv();
        drive(1, 32'h100, 0, 0, 1, 0, 32'hBADBAD00);
        chk("fl_d_stall", 32'(stall_req_out), 1);
        chk("fl_d_valid", 32'(inst_valid_out), 0);
        adv();
        drive(1, 32'h100, 0, 0, 0, 0, 32'h0);
        chk("fl_e_req",   32'(bus_req_out), 0);
        chk("fl_e_valid", 32'(inst_valid_out), 0);
        chk("fl_e_inst",  inst_out, NOP);
        chk("fl_e_ferr",  32'(fetch_err_out), 0);
        adv();
        drive(1, 32'h100, 0, 0, 1, 0, 32'h00000093);
        chk("fl_f_req",   32'(bus_req_out), 1);
        chk("fl_f_addr",  bus_addr_out, 32'h100);
        adv();
        drive(0, 32'h104, 0, 0, 0, 0, 32'h0);
        chk("fl_g_valid", 32'(inst_valid_out), 1);
        chk("fl_g_inst",  inst_out, 32'h00000093);
        chk("fl_g_ipc",   inst_pc_out, 32'h100);
        adv();

        // No reply: request must stay up for exactly 255 cycles, then a NOP with an error pulse.
        drive(1, 32'h40, 0, 0, 0, 0, 32'h0);
        adv();
        n = 0;
        gone = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive(1, 32'h40, 0, 0, 0, 0, 32'h0);
            if (bus_req_out !== 1'b1) begin
                gone = 1'b1;
                break;
            end
            n++;
            adv();
        end
        chk("to_dropped", 32'(gone), 1);
        chk("to_len",     32'(n), 255);
        chk("to_inst",    inst_out, NOP);
        chk("to_ferr",    32'(fetch_err_out), 1);
        chk("to_valid",   32'(inst_valid_out), 1);
        adv();
        drive(1, 32'h40, 0, 0, 1, 0, 32'h11111111);
        chk("to_ferr_w1", 32'(fetch_err_out), 0);
        chk("to_re_req",  32'(bus_req_out), 1);
        chk("to_re_addr", bus_addr_out, 32'h40);
        adv();
        drive(0, 32'h44, 0, 0, 0, 0, 32'h0);
        chk("to_re_valid", 32'(inst_valid_out), 1);
        chk("to_re_inst",  inst_out, 32'h11111111);
        chk("to_re_ipc",   inst_pc_out, 32'h40);
        adv();

        // Reset during REQ, ack arrives the cycle after.
        drive(1, 32'h80, 0, 0, 0, 0, 32'h0);
        adv();
        reset_in = 1'b1;
        drive(1, 32'h80, 0, 0, 0, 0, 32'h0);
        chk("mr_req_before", 32'(bus_req_out), 1);
        adv();
        reset_in = 1'b0;
        drive(0, 32'h80, 0, 0, 1, 0, 32'hCAFEF00D);
        chk("mr_req",   32'(bus_req_out), 0);
        chk("mr_addr",  bus_addr_out, 0);
        chk("mr_inst",  inst_out, NOP);
        chk("mr_ipc",   inst_pc_out, 0);
        chk("mr_valid", 32'(inst_valid_out), 0);
        chk("mr_stall", 32'(stall_req_out), 0);
        adv();
        drive(0, 32'h80, 0, 0, 0, 0, 32'h0);
        chk("mr_late_valid", 32'(inst_valid_out), 0);
        chk("mr_late_inst",  inst_out, NOP);
        chk("mr_late_req",   32'(bus_req_out), 0);
        chk("mr_late_ferr",  32'(fetch_err_out), 0);
        adv();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
